hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter MD_CYCLES, default 4, mul/div latency in cycles (legal range 2..15).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port id_rs  input  5  rs of instruction in ID.
REQ-005 SHALL provide port id_rt  input  5  rt of instruction in ID.
REQ-006 SHALL provide port id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 SHALL provide port id_md_read  input  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-008 SHALL provide port ex_rt  input  5  destination of the load in EX.
REQ-009 SHALL provide port ex_memread  input  1  EX instruction is a load.
REQ-010 SHALL provide port ex_md_start  input  1  mul/div issues from EX this cycle.
REQ-011 SHALL provide port ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-012 SHALL provide port pc_write  output  1  PC update enable.
REQ-013 SHALL provide port ifid_write  output  1  IF/ID register enable.
REQ-014 SHALL provide port ifid_flush  output  1  clear IF/ID to NOP.
REQ-015 SHALL provide port idex_bubble  output  1  load NOP into ID/EX.
REQ-016 SHALL provide port md_busy  output  1  mul/div result not yet valid.

Function
REQ-017 SHALL detect load-use as: ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-018 On load-use SHALL drive, in the same cycle, pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; stall lasts exactly one cycle because the bubble removes the load match.
REQ-019 SHALL implement two states: IDLE and MD_WAIT, with internal 4-bit down-counter.
REQ-020 In IDLE with ex_md_start=1 SHALL load counter with MD_CYCLES and move to MD_WAIT next edge.
REQ-021 In MD_WAIT SHALL decrement counter each edge and return to IDLE on the edge where counter equals 1.
REQ-022 md_busy SHALL equal (state==MD_WAIT), giving exactly MD_CYCLES busy cycles starting the cycle after ex_md_start.
REQ-023 ex_md_start in MD_WAIT SHALL reload counter with MD_CYCLES and remain in MD_WAIT (restart, no queueing).
REQ-024 When md_busy && id_md_read SHALL drive pc_write=0, ifid_write=0, idex_bubble=1 for every such cycle.
REQ-025 On ex_branch_taken SHALL drive ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, overriding load-use and md stalls that cycle.
REQ-026 ex_branch_taken SHALL NOT affect the MD state machine; concurrent ex_md_start is still accepted.
REQ-027 With no hazard SHALL drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-028 Load-use and md stall in the same cycle SHALL produce a single stall (same output values, no extra cycle).

Reset
REQ-029 While rst=1 SHALL force state IDLE, counter 0, md_busy=0, and drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0 regardless of inputs.
REQ-030 rst asserted during MD_WAIT SHALL abort the countdown; first cycle after rst deasserts is IDLE.

Configuration
REQ-031 With macro HAZARD_STALL_CNT_EN defined SHALL add output stall_count (32-bit): +1 each cycle with pc_write=0, saturating at 0xFFFFFFFF, cleared by rst.
REQ-032 Without HAZARD_STALL_CNT_EN SHALL omit the stall_count port and its register; all other behaviour identical.

Verification
REQ-033 ex_memread=1, ex_rt=8, id_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_memread=0) all normal.
REQ-034 ex_memread=1, ex_rt=0, id_rs=0 -> no stall; ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
REQ-035 MD_CYCLES=4, ex_md_start pulse at cycle 0, id_md_read=1 held -> md_busy and stall in cycles 1-4, pc_write=1 at cycle 5.
REQ-036 ex_md_start again at cycle 2 of a 4-cycle wait -> md_busy held through cycle 6.
REQ-037 ex_branch_taken=1 concurrent with load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
REQ-038 rst=1 in MD_WAIT -> md_busy=0 next cycle; with HAZARD_STALL_CNT_EN, 3 stall cycles then rst -> stall_count 3 then 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, mul/div busy and branch-flush pipeline hazard control; HAZARD_STALL_CNT_EN adds stall_count
module hazard_ctrl #(
  parameter int MD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_md_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_memread,
  input  logic       ex_md_start,
  input  logic       ex_branch_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic {IDLE, MD_WAIT} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic load_use, stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (ex_md_start) begin
      state_n = MD_WAIT;
      cnt_n   = 4'(MD_CYCLES);
    end else if (state == MD_WAIT) begin
      cnt_n   = cnt - 4'd1;
      state_n = (cnt == 4'd1) ? IDLE : MD_WAIT;
    end
  end
  // busy is masked while rst is high so a reset in MD_WAIT never stalls
  assign md_busy  = (state == MD_WAIT) && !rst;
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign stall    = !rst && (load_use || (md_busy && id_md_read));
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst && ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (!pc_write && stall_count != '1) stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus multi-cycle sequences for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, id_uses_rt, id_md_read, ex_memread, ex_md_start, ex_branch_taken;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_count;
`endif
  int n_run = 0, n_fail = 0;

  hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_read(id_md_read), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .md_busy(md_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy}
  localparam logic [4:0] NORM = 5'b11000, STALL = 5'b00010, FLUSH = 5'b11110;
  localparam logic [4:0] NORM_B = 5'b11001, STALL_B = 5'b00011, FLUSH_B = 5'b11111;

  typedef struct {
    string      name;
    logic       r;
    logic [4:0] rs, rt;
    logic       uses_rt, md_read;
    logic [4:0] xrt;
    logic       memread, md_start, branch;
    logic [4:0] exp;
  } vec_t;
  vec_t v[12];

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic mr, input logic [4:0] xrt,
                       input logic mem, input logic ms, input logic br);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = ur; id_md_read = mr;
    ex_rt = xrt; ex_memread = mem; ex_md_start = ms; ex_branch_taken = br;
  endtask

  task automatic check_cycle(input string name, input logic [4:0] exp);
    logic [4:0] act;
    @(negedge clk);
    act = {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = '{"reset_forces_normal", 1, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0, NORM};
    v[1]  = '{"no_hazard",           0, 5'd1, 5'd2, 1, 0, 5'd3, 0, 0, 0, NORM};
    v[2]  = '{"loaduse_rs",          0, 5'd8, 5'd0, 0, 0, 5'd8, 1, 0, 0, STALL};
    v[3]  = '{"after_loaduse",       0, 5'd8, 5'd0, 0, 0, 5'd8, 0, 0, 0, NORM};
    v[4]  = '{"loaduse_r0",          0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, NORM};
    v[5]  = '{"rt_not_used",         0, 5'd1, 5'd9, 0, 0, 5'd9, 1, 0, 0, NORM};
    v[6]  = '{"loaduse_rt",          0, 5'd1, 5'd9, 1, 0, 5'd9, 1, 0, 0, STALL};
    v[7]  = '{"load_no_match",       0, 5'd4, 5'd5, 1, 0, 5'd6, 1, 0, 0, NORM};
    v[8]  = '{"branch_over_loaduse", 0, 5'd8, 5'd0, 0, 0, 5'd8, 1, 0, 1, FLUSH};
    v[9]  = '{"branch_alone",        0, 5'd1, 5'd2, 1, 0, 5'd3, 0, 0, 1, FLUSH};
    v[10] = '{"mdread_idle",         0, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, NORM};
    v[11] = '{"rst_with_branch",     1, 5'd1, 5'd2, 1, 0, 5'd3, 0, 0, 1, NORM};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      drive(v[i].r, v[i].rs, v[i].rt, v[i].uses_rt, v[i].md_read, v[i].xrt,
            v[i].memread, v[i].md_start, v[i].branch);
      check_cycle(v[i].name, v[i].exp);
    end

    drive(0, 1, 2, 0, 1, 3, 0, 1, 0);
    check_cycle("md4_c0", NORM);
    ex_md_start = 0;
    for (int c = 1; c <= 4; c++) check_cycle($sformatf("md4_c%0d", c), STALL_B);
    check_cycle("md4_c5", NORM);

    drive(0, 1, 2, 0, 0, 3, 0, 1, 0);
    check_cycle("restart_c0", NORM);
    ex_md_start = 0;
    check_cycle("restart_c1", NORM_B);
    ex_md_start = 1;
    check_cycle("restart_c2", NORM_B);
    ex_md_start = 0; id_md_read = 1; ex_branch_taken = 1;
    check_cycle("restart_c3_branch", FLUSH_B);
    ex_branch_taken = 0; ex_memread = 1; ex_rt = 5'd1;
    check_cycle("restart_c4_dual", STALL_B);
    ex_memread = 0;
    check_cycle("restart_c5", STALL_B);
    check_cycle("restart_c6", STALL_B);
    check_cycle("restart_c7", NORM);

    drive(0, 1, 2, 0, 0, 3, 0, 1, 1);
    check_cycle("branch_md_start", FLUSH);
    drive(0, 1, 2, 0, 0, 3, 0, 0, 0);
    check_cycle("branch_md_busy", NORM_B);
    id_md_read = 1; rst = 1;
    check_cycle("rst_in_wait", NORM);
    rst = 0;
    check_cycle("after_rst_idle", NORM);

`ifdef HAZARD_STALL_CNT_EN
    drive(0, 8, 0, 0, 0, 8, 1, 0, 0);
    for (int c = 0; c < 3; c++) check_cycle("cnt_stall", STALL);
    drive(0, 1, 2, 0, 0, 3, 0, 0, 0);
    @(negedge clk);
    n_run++;
    if (stall_count !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_count3: got %0d expected 3", stall_count);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_run++;
    if (stall_count !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_count_rst: got %0d expected 0", stall_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
